lcd_refresh: RTL and testbench

LCD_REFRESH -- requirements
Module: lcd_refresh

---
 rtl/lcd_pkg.sv | 43 ++++
 rtl/lcd_char_buf.sv | 41 ++++
 rtl/lcd_refresh.sv | 197 +++++++++++++++++++
 tb/tb_lcd_refresh.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780 refresh engine: controller state encoding,
// the HD44780 command bytes used by the init sequence and refresh passes, and
// small helpers for compile-time sizing and init-sequence lookup.
// -----------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
        S_POWER,
        S_SETUP,
        S_PULSE,
        S_WAIT,
        S_IDLE
    } lcd_state_t;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_LINE0    = 8'h80;
    localparam logic [7:0] LCD_LINE1    = 8'hC0;
    localparam logic [7:0] LCD_SPACE    = 8'h20;

    // Init sequence length and the position of Clear inside it (Clear needs
    // the long post-transfer wait).
    localparam int INIT_LEN  = 4;
    localparam int CLEAR_IDX = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] init_cmd(input int idx);
        case (idx)
            0:       return LCD_FUNC_SET;
            1:       return LCD_ENTRY;
            2:       return LCD_DISP_ON;
            default: return LCD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_char_buf.sv
// -----------------------------------------------------------------------------
// lcd_char_buf
// COLS*ROWS x 8 character buffer holding what the LCD should display.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset (fills buffer with spaces)
//   i_wr_en          write strobe (caller guarantees the address is in range)
//   i_wr_addr        write index
//   i_wr_data        ASCII code to store
//   i_rd_addr        combinational read index
//   o_rd_data        byte at i_rd_addr
// -----------------------------------------------------------------------------
module lcd_char_buf
    import lcd_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= LCD_SPACE;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/lcd_refresh.sv
// -----------------------------------------------------------------------------
// lcd_refresh
// Drives an HD44780 character LCD in 8-bit mode from a local character buffer.
// After reset it waits for LCD power-on, sends the init sequence, performs one
// full redraw, then idles until a redraw is requested (REFRESH, or the buffer
// being dirty when AUTO=1).
// Ports:
//   CLOCK_50          single clock, rising edge
//   RST               async active-low reset
//   WR_EN/WR_ADDR/WR_CHAR  buffer write port (out-of-range addresses ignored)
//   REFRESH           one-cycle redraw request, honoured only when idle
//   BUSY              high whenever the controller is not idle
//   LCD_EN/LCD_RS/LCD_RW/LCD_DATA  HD44780 bus (RW tied low)
// -----------------------------------------------------------------------------
module lcd_refresh
    import lcd_pkg::*;
#(
    parameter int COLS        = 16,
    parameter int ROWS        = 2,
    parameter int POWERON_CYC = 750000,
    parameter int EN_CYC      = 12,
    parameter int CMD_CYC     = 2500,
    parameter int CLR_CYC     = 100000,
    parameter int AUTO        = 0
) (
    input  logic                              CLOCK_50,
    input  logic                              RST,
    input  logic                              WR_EN,
    // One code wider than the last cell so that out-of-range indices can be
    // presented (and rejected) even when COLS*ROWS is a power of two.
    input  logic [$clog2(COLS*ROWS+1)-1:0]    WR_ADDR,
    input  logic [7:0]                        WR_CHAR,
    input  logic                              REFRESH,
    output logic                              BUSY,
    output logic                              LCD_EN,
    output logic                              LCD_RS,
    output logic                              LCD_RW,
    output logic [7:0]                        LCD_DATA
);

    localparam int NCHAR   = COLS * ROWS;
    localparam int BUF_AW  = (NCHAR > 1) ? $clog2(NCHAR) : 1;
    localparam int SEQ_LEN = INIT_LEN + ROWS * (COLS + 1);
    localparam int IDX_W   = $clog2(SEQ_LEN);
    localparam int MAX_CYC = max_int(max_int(POWERON_CYC, EN_CYC), max_int(CMD_CYC, CLR_CYC));
    localparam int CNT_W   = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;

    lcd_state_t       r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [IDX_W-1:0] r_idx, w_idx_nx;
    logic             r_dirty;
    logic             r_rs;
    logic [7:0]       r_data;
    logic             w_seq_rs;
    logic [7:0]       w_seq_data;
    logic [BUF_AW-1:0] w_rd_addr;
    logic [7:0]       w_rd_data;
    logic             w_wr_ok;
    logic             w_start;

    assign w_wr_ok = WR_EN && (32'(WR_ADDR) < 32'(NCHAR));
    assign w_start = REFRESH || ((AUTO != 0) && r_dirty);

    lcd_char_buf #(
        .DEPTH (NCHAR),
        .AW    (BUF_AW)
    ) u_buf (
        .i_clk     (CLOCK_50),
        .i_rst_n   (RST),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (BUF_AW'(WR_ADDR)),
        .i_wr_data (WR_CHAR),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Sequence index -> transfer. Indices below INIT_LEN are the init
    // commands; the rest form the redraw pass, laid out per row as one
    // line-address command followed by COLS characters.
    always_comb begin
        int p;
        int row;
        int col;
        p          = 0;
        row        = 0;
        col        = 0;
        w_seq_rs   = 1'b0;
        w_seq_data = 8'h00;
        w_rd_addr  = '0;
        if (int'(r_idx) < INIT_LEN) begin
            w_seq_data = init_cmd(int'(r_idx));
        end else begin
            p   = int'(r_idx) - INIT_LEN;
            row = p / (COLS + 1);
            col = p % (COLS + 1);
            if (col == 0) begin
                w_seq_data = (row == 0) ? LCD_LINE0 : LCD_LINE1;
            end else begin
                w_seq_rs   = 1'b1;
                w_rd_addr  = BUF_AW'(row * COLS + col - 1);
                w_seq_data = w_rd_data;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST) begin
        if (!RST) begin
            r_state <= S_POWER;
            r_cnt   <= CNT_W'(POWERON_CYC);
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
        end
    end

    // One shared down-counter times every phase; it is reloaded on each
    // phase entry and a phase ends when it reaches 1.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        case (r_state)
            S_POWER: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nx = S_SETUP;
                    w_idx_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            S_SETUP: begin
                w_state_nx = S_PULSE;
                w_cnt_nx   = CNT_W'(EN_CYC);
            end
            S_PULSE: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nx = S_WAIT;
                    w_cnt_nx   = (r_idx == IDX_W'(CLEAR_IDX)) ? CNT_W'(CLR_CYC) : CNT_W'(CMD_CYC);
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (r_cnt <= CNT_W'(1)) begin
                    if (r_idx == IDX_W'(SEQ_LEN - 1)) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_SETUP;
                        w_idx_nx   = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (w_start) begin
                    w_state_nx = S_SETUP;
                    w_idx_nx   = IDX_W'(INIT_LEN);
                end
            end
            default: begin
                w_state_nx = S_POWER;
                w_cnt_nx   = CNT_W'(POWERON_CYC);
            end
        endcase
    end

    // RS/DATA are driven combinationally during setup and then frozen, so a
    // buffer write mid-transfer cannot disturb the byte on the bus. Dirty is
    // cleared when a pass starts; a simultaneous write keeps it set.
    always_ff @(posedge CLOCK_50 or negedge RST) begin
        if (!RST) begin
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_dirty <= 1'b0;
        end else begin
            if (r_state == S_SETUP) begin
                r_rs   <= w_seq_rs;
                r_data <= w_seq_data;
            end
            if (w_wr_ok) begin
                r_dirty <= 1'b1;
            end else if ((r_state == S_SETUP) && (r_idx == IDX_W'(INIT_LEN))) begin
                r_dirty <= 1'b0;
            end
        end
    end

    assign BUSY     = (r_state != S_IDLE);
    assign LCD_EN   = (r_state == S_PULSE);
    assign LCD_RS   = (r_state == S_SETUP) ? w_seq_rs : r_rs;
    assign LCD_DATA = (r_state == S_SETUP) ? w_seq_data : r_data;
    assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_refresh.sv
// -----------------------------------------------------------------------------
// tb_lcd_refresh
// Two instances of lcd_refresh share clock and reset: instance 0 with AUTO=0
// and instance 1 with AUTO=1. A bus monitor turns each EN pulse into a
// transfer record; the directed sequence compares those records against the
// expected command/character stream built from a plain character-array model.
// -----------------------------------------------------------------------------
module tb_lcd_refresh;
    import lcd_pkg::*;

    localparam int COLS        = 4;
    localparam int ROWS        = 2;
    localparam int POWERON_CYC = 10;
    localparam int EN_CYC      = 2;
    localparam int CMD_CYC     = 3;
    localparam int CLR_CYC     = 6;
    localparam int NCHAR       = COLS * ROWS;
    localparam int TIMEOUT     = 100;

    typedef struct {
        int         dut;
        logic       rs;
        logic [7:0] data;
        int         rise;
        int         fall;
        bit         stable;
    } xfer_t;

    logic       clock = 1'b0;
    logic       rstN  = 1'b1;
    logic       wrEn    [2];
    logic [3:0] wrAddr  [2];
    logic [7:0] wrChar  [2];
    logic       refresh [2];
    logic       busy    [2];
    logic       lcdEn   [2];
    logic       lcdRs   [2];
    logic       lcdRw   [2];
    logic [7:0] lcdData [2];

    logic [7:0] modelBuf [2][NCHAR];
    xfer_t      xq[$];
    xfer_t      cur [2];
    logic       prevEn [2] = '{1'b0, 1'b0};
    bit         lastValid [2];
    int         lastFall [2];
    int         lastWait [2];
    int         cyc       = 0;
    int         rwErrors  = 0;
    int         checks    = 0;
    int         failures  = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : gDut
            lcd_refresh #(
                .COLS        (COLS),
                .ROWS        (ROWS),
                .POWERON_CYC (POWERON_CYC),
                .EN_CYC      (EN_CYC),
                .CMD_CYC     (CMD_CYC),
                .CLR_CYC     (CLR_CYC),
                .AUTO        (g)
            ) dut (
                .CLOCK_50 (clock),
                .RST      (rstN),
                .WR_EN    (wrEn[g]),
                .WR_ADDR  (wrAddr[g]),
                .WR_CHAR  (wrChar[g]),
                .REFRESH  (refresh[g]),
                .BUSY     (busy[g]),
                .LCD_EN   (lcdEn[g]),
                .LCD_RS   (lcdRs[g]),
                .LCD_RW   (lcdRw[g]),
                .LCD_DATA (lcdData[g])
            );
        end
    endgenerate

    // Bus monitor: one record per EN pulse, noting rise/fall cycle and
    // whether RS/DATA moved while EN was high.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (lcdEn[d] && !prevEn[d]) begin
                cur[d].dut    = d;
                cur[d].rs     = lcdRs[d];
                cur[d].data   = lcdData[d];
                cur[d].rise   = cyc;
                cur[d].stable = 1'b1;
            end else if (lcdEn[d] && prevEn[d]) begin
                if (lcdRs[d] !== cur[d].rs || lcdData[d] !== cur[d].data) cur[d].stable = 1'b0;
            end else if (!lcdEn[d] && prevEn[d]) begin
                cur[d].fall = cyc;
                xq.push_back(cur[d]);
            end
            if (lcdRw[d] !== 1'b0) rwErrors++;
            prevEn[d] = lcdEn[d];
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [3:0] addr, input logic [7:0] ch);
        @(negedge clock);
        wrEn[d]   = 1'b1;
        wrAddr[d] = addr;
        wrChar[d] = ch;
        if (addr < NCHAR) modelBuf[d][addr] = ch;
        @(posedge clock);
        #1 wrEn[d] = 1'b0;
    endtask

    task automatic pulseRefresh(input int d);
        @(negedge clock);
        refresh[d] = 1'b1;
        @(posedge clock);
        #1 refresh[d] = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic waitIdle(input int d, input string tag);
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clock);
            if (!busy[d]) break;
        end
        checkOutput(tag, busy[d], 1'b0);
    endtask

    task automatic resetModel();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NCHAR; i++) modelBuf[d][i] = LCD_SPACE;
    endtask

    function automatic int countXfers(input int d);
        int n = 0;
        foreach (xq[i]) if (xq[i].dut == d) n++;
        return n;
    endfunction

    task automatic popXfer(input int d, output xfer_t x, output bit ok);
        int waited = 0;
        x  = '{default: 0};
        ok = 1'b0;
        while (!ok && waited < TIMEOUT) begin
            for (int i = 0; i < xq.size(); i++) begin
                if (xq[i].dut == d) begin
                    x = xq[i];
                    xq.delete(i);
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                @(posedge clock);
                waited++;
            end
        end
    endtask

    task automatic checkXfer(input string tag, input int d, input logic expRs,
                             input logic [7:0] expData, input int expWait, output int rise);
        xfer_t x;
        bit    ok;
        popXfer(d, x, ok);
        rise = x.rise;
        checkOutput({tag, ".arrived"}, ok, 1'b1);
        if (ok) begin
            checkOutput({tag, ".rs"}, x.rs, expRs);
            checkOutput({tag, ".data"}, x.data, expData);
            checkOutput({tag, ".enWidth"}, x.fall - x.rise, EN_CYC);
            checkOutput({tag, ".stable"}, x.stable, 1'b1);
            if (lastValid[d]) checkOutput({tag, ".gap"}, x.rise - lastFall[d], lastWait[d] + 1);
            lastValid[d] = 1'b1;
            lastFall[d]  = x.fall;
            lastWait[d]  = expWait;
        end
    endtask

    task automatic checkInit(input int d, input int relCyc);
        int rise;
        lastValid[d] = 1'b0;
        checkXfer($sformatf("d%0d.init38", d), d, 1'b0, 8'h38, CMD_CYC, rise);
        checkOutput($sformatf("d%0d.firstEnRise", d), rise - relCyc, POWERON_CYC + 1);
        checkXfer($sformatf("d%0d.init06", d), d, 1'b0, 8'h06, CMD_CYC, rise);
        checkXfer($sformatf("d%0d.init0C", d), d, 1'b0, 8'h0C, CMD_CYC, rise);
        checkXfer($sformatf("d%0d.init01", d), d, 1'b0, 8'h01, CLR_CYC, rise);
    endtask

    // Expected pass: line address command then that row's characters, read
    // from the model at the moment each character is due on the bus.
    task automatic checkPass(input int d, input bit chained, input int midAddr, input logic [7:0] midChar);
        int rise;
        if (!chained) lastValid[d] = 1'b0;
        for (int row = 0; row < ROWS; row++) begin
            checkXfer($sformatf("d%0d.line%0d", d, row), d, 1'b0,
                      (row == 0) ? 8'h80 : 8'hC0, CMD_CYC, rise);
            if (row == 1 && midAddr >= 0) applyStimulus(d, midAddr[3:0], midChar);
            for (int col = 0; col < COLS; col++)
                checkXfer($sformatf("d%0d.char%0d", d, row * COLS + col), d, 1'b1,
                          modelBuf[d][row * COLS + col], CMD_CYC, rise);
        end
    endtask

    task automatic checkReset(input string tag);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s.d%0d.busy", tag, d), busy[d], 1'b1);
            checkOutput($sformatf("%s.d%0d.en", tag, d), lcdEn[d], 1'b0);
            checkOutput($sformatf("%s.d%0d.rs", tag, d), lcdRs[d], 1'b0);
            checkOutput($sformatf("%s.d%0d.data", tag, d), lcdData[d], 8'h00);
        end
    endtask

    initial begin
        int         relCyc;
        logic [7:0] c;
        for (int d = 0; d < 2; d++) begin
            wrEn[d]    = 1'b0;
            wrAddr[d]  = 4'd0;
            wrChar[d]  = 8'h00;
            refresh[d] = 1'b0;
        end
        resetModel();

        #2 rstN = 1'b0;
        waitCycles(2);
        checkReset("por");

        @(posedge clock);
        #1 rstN = 1'b1;
        relCyc = cyc;
        for (int d = 0; d < 2; d++) begin
            checkInit(d, relCyc);
            checkPass(d, 1'b1, -1, 8'h00);
        end
        waitIdle(0, "d0.idleAfterInit");
        waitIdle(1, "d1.idleAfterInit");

        applyStimulus(0, 4'd5, 8'h41);
        waitCycles(10);
        checkOutput("d0.noAutoStart", busy[0], 1'b0);
        pulseRefresh(0);
        pulseRefresh(0);
        checkPass(0, 1'b0, -1, 8'h00);
        waitIdle(0, "d0.idleAfterRefresh");
        waitCycles(15);
        checkOutput("d0.refreshWhileBusyIgnored", countXfers(0), 0);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++)
                applyStimulus(0, 4'($urandom_range(0, 11)), 8'($urandom_range(33, 126)));
            waitCycles(3);
            checkOutput($sformatf("d0.round%0d.staysIdle", r), busy[0], 1'b0);
            pulseRefresh(0);
            checkPass(0, 1'b0, -1, 8'h00);
            waitIdle(0, $sformatf("d0.round%0d.idle", r));
        end

        applyStimulus(1, 4'd9, 8'h5A);
        waitCycles(15);
        checkOutput("d1.oobNoPass.busy", busy[1], 1'b0);
        checkOutput("d1.oobNoPass.xfers", countXfers(1), 0);
        pulseRefresh(1);
        checkPass(1, 1'b0, -1, 8'h00);
        waitIdle(1, "d1.idleAfterOob");

        c = 8'($urandom_range(33, 126));
        pulseRefresh(1);
        checkPass(1, 1'b0, 0, c);
        checkPass(1, 1'b0, -1, 8'h00);
        checkOutput("d1.autoPassNewChar", modelBuf[1][0], c);
        waitIdle(1, "d1.idleAfterAuto");
        waitCycles(15);
        checkOutput("d1.noThirdPass", countXfers(1), 0);

        pulseRefresh(0);
        for (int i = 0; i < TIMEOUT; i++) begin
            @(posedge clock);
            #1;
            if (lcdEn[0]) break;
        end
        checkOutput("d0.enHighBeforeReset", lcdEn[0], 1'b1);
        rstN = 1'b0;
        #1;
        checkReset("midPulse");
        waitCycles(3);
        xq.delete();
        resetModel();
        @(posedge clock);
        #1 rstN = 1'b1;
        relCyc = cyc;
        for (int d = 0; d < 2; d++) begin
            checkInit(d, relCyc);
            checkPass(d, 1'b1, -1, 8'h00);
        end
        waitIdle(0, "d0.idleAfterReinit");
        waitIdle(1, "d1.idleAfterReinit");

        checkOutput("rwTied0", rwErrors, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
